// File: rtl/riscv_enc_pkg.sv
// Shared RV32I encoder types: instruction formats, opcodes, NOP word and loader FSM states.
// Pure declarations; no logic, latency or flow control.
package riscv_enc_pkg;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Combinational RV32I field packer with immediate range/alignment check; zero latency.
// No flow control: instr and legal follow the inputs directly.
module imm_pack
   import riscv_enc_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [6:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] imm,
   output logic [31:0] instr,
   output logic        legal
);

   logic sext_11;
   logic sext_12;
   logic sext_20;

   // Upper bits must be pure sign extension of the field's top bit.
   assign sext_11 = (&imm[31:11]) | ~(|imm[31:11]);
   assign sext_12 = (&imm[31:12]) | ~(|imm[31:12]);
   assign sext_20 = (&imm[31:20]) | ~(|imm[31:20]);

   always_comb begin
      instr = NOP_INSTR;
      legal = 1'b0;
      case (fmt)
         FMT_R: begin
            instr = {funct7, rs2, rs1, funct3, rd, opcode};
            legal = 1'b1;
         end
         FMT_I: begin
            instr = {imm[11:0], rs1, funct3, rd, opcode};
            legal = sext_11;
         end
         FMT_S: begin
            instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            legal = sext_11;
         end
         FMT_B: begin
            instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            legal = sext_12 & ~imm[0];
         end
         FMT_U: begin
            instr = {imm[31:12], rd, opcode};
            legal = ~(|imm[11:0]);
         end
         FMT_J: begin
            instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            legal = sext_20 & ~imm[0];
         end
         default: begin
            instr = NOP_INSTR;
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Burst loader: encodes field beats into RV32I words written at consecutive word addresses.
// One-cycle accept-to-output latency; a stalled output beat holds and blocks further accepts.
module instr_encoder
   import riscv_enc_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16,
   parameter int ERR_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  num_instr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        fmt,
   input  logic [6:0]        opcode,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic [31:0]       imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_err,
   output logic [ERR_W-1:0]  err_cnt,
   output logic              busy,
   output logic              done
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  remaining_q, remaining_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              out_valid_q, out_valid_d;
   logic [31:0]       out_instr_q, out_instr_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic              out_err_q, out_err_d;
   logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

   logic [31:0]       packed_instr;
   logic              packed_legal;
   logic              accept;
   logic [ADDR_W-1:0] base_aligned;

   imm_pack u_imm_pack (
      .fmt    (fmt),
      .opcode (opcode),
      .rd     (rd),
      .rs1    (rs1),
      .rs2    (rs2),
      .funct3 (funct3),
      .funct7 (funct7),
      .imm    (imm),
      .instr  (packed_instr),
      .legal  (packed_legal)
   );

   assign base_aligned = base_addr & ~ADDR_W'(3);
   assign accept       = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_LOAD;
         // Leave only once the final beat has drained (or none was ever pending).
         ST_LOAD: if ((remaining_q == '0) && (!out_valid_q || out_ready)) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_q == ST_LOAD) && (remaining_q != '0) && (!out_valid_q || out_ready);
      busy     = (state_q != ST_IDLE);
      done     = (state_q == ST_DONE);
   end

   always_comb begin
      remaining_d = remaining_q;
      addr_d      = addr_q;
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_addr_d  = out_addr_q;
      out_err_d   = out_err_q;
      err_cnt_d   = err_cnt_q;
      if ((state_q == ST_IDLE) && start) begin
         addr_d      = base_aligned;
         remaining_d = num_instr;
         err_cnt_d   = '0;
      end
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      if (accept) begin
         out_valid_d = 1'b1;
         out_instr_d = packed_legal ? packed_instr : NOP_INSTR;
         out_err_d   = ~packed_legal;
         out_addr_d  = addr_q;
         addr_d      = addr_q + ADDR_W'(4);
         remaining_d = remaining_q - CNT_W'(1);
         if (!packed_legal && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remaining_q <= '0;
         addr_q      <= '0;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_addr_q  <= '0;
         out_err_q   <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         remaining_q <= remaining_d;
         addr_q      <= addr_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_addr_q  <= out_addr_d;
         out_err_q   <= out_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_instr = out_instr_q;
   assign out_addr  = out_addr_q;
   assign out_err   = out_err_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: fixed vectors, corner-case sequences and random bursts vs a decode-based model.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n, start, in_valid, in_ready, out_valid, out_ready, out_err, busy, done;
   logic [31:0] base_addr, imm, out_instr, out_addr;
   logic [15:0] num_instr;
   logic [2:0]  fmt, funct3;
   logic [6:0]  opcode, funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [7:0]  err_cnt;

   instr_encoder #(.ADDR_W(32), .CNT_W(16), .ERR_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_instr(num_instr),
      .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode), .rd(rd),
      .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
      .out_err(out_err), .err_cnt(err_cnt), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  fmt;
      logic [6:0]  op;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic        exact;
      logic [31:0] exp_instr;
   } beat_t;

   typedef struct {
      beat_t       b;
      logic [31:0] addr;
   } sb_t;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   sb_t         sbq[$];
   logic [31:0] m_addr = 0;
   int          m_err = 0;
   int          m_pops = 0;
   logic        cur_exact = 1'b0;
   logic [31:0] cur_exp = 0;
   logic        rand_rdy = 1'b0;
   beat_t       vec[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   function automatic beat_t mk(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                                input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                                input logic [31:0] im, input logic [31:0] ex);
      beat_t b;
      b.fmt = f; b.op = op; b.rd = d; b.rs1 = s1; b.rs2 = s2; b.f3 = f3; b.f7 = 7'd0;
      b.imm = im; b.exact = 1'b1; b.exp_instr = ex;
      return b;
   endfunction

   // Legality from the numeric range each format's immediate field can represent.
   function automatic bit ref_legal(input beat_t b);
      longint s = longint'($signed(b.imm));
      case (b.fmt)
         3'd0:    return 1'b1;
         3'd1,
         3'd2:    return (s >= -2048) && (s <= 2047);
         3'd3:    return (s >= -4096) && (s <= 4095) && (s % 2 == 0);
         3'd4:    return (b.imm % 32'd4096) == 0;
         3'd5:    return (s >= -(64'sd1 << 20)) && (s < (64'sd1 << 20)) && (s % 2 == 0);
         default: return 1'b0;
      endcase
   endfunction

   // Core-style immediate generator: recovers the immediate from an encoded word.
   function automatic logic [31:0] ref_imm(input logic [2:0] f, input logic [31:0] i);
      case (f)
         3'd1:    return {{20{i[31]}}, i[31:20]};
         3'd2:    return {{20{i[31]}}, i[31:25], i[11:7]};
         3'd3:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         3'd4:    return {i[31:12], 12'd0};
         3'd5:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit ref_fields_ok(input beat_t b, input logic [31:0] i);
      bit ok = (i[6:0] == b.op);
      case (b.fmt)
         3'd0: ok = ok && i[11:7] == b.rd && i[14:12] == b.f3 && i[19:15] == b.rs1
                       && i[24:20] == b.rs2 && i[31:25] == b.f7;
         3'd1: ok = ok && i[11:7] == b.rd && i[14:12] == b.f3 && i[19:15] == b.rs1;
         3'd2,
         3'd3: ok = ok && i[14:12] == b.f3 && i[19:15] == b.rs1 && i[24:20] == b.rs2;
         default: ok = ok && i[11:7] == b.rd;
      endcase
      if (b.fmt != 3'd0) ok = ok && (ref_imm(b.fmt, i) == b.imm);
      return ok;
   endfunction

   function automatic beat_t rand_beat();
      beat_t b;
      b.fmt = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      b.op = 7'($urandom); b.rd = 5'($urandom); b.rs1 = 5'($urandom); b.rs2 = 5'($urandom);
      b.f3 = 3'($urandom); b.f7 = 7'($urandom); b.exact = 1'b0; b.exp_instr = 32'd0;
      case (b.fmt)
         3'd1, 3'd2: b.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
         3'd3:       b.imm = (32'($urandom_range(0, 4095)) - 32'd2048) * 2;
         3'd4:       b.imm = $urandom & 32'hFFFFF000;
         3'd5:       b.imm = (32'($urandom_range(0, 1048575)) - 32'd524288) * 2;
         default:    b.imm = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) b.imm = $urandom;
      return b;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
   end

   // Monitor: retire output handshakes against the scoreboard, then log new accepts.
   initial begin : monitor
      logic        hold_vld;
      logic [31:0] hold_instr, hold_addr;
      logic        hold_err;
      sb_t         e;
      beat_t       nb;
      hold_vld = 1'b0; hold_instr = 0; hold_addr = 0; hold_err = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold_vld = 1'b0;
         end else begin
            if (hold_vld) begin
               check("hold_valid", 32'(out_valid), 32'd1);
               check("hold_instr", out_instr, hold_instr);
               check("hold_addr", out_addr, hold_addr);
               check("hold_err", 32'(out_err), 32'(hold_err));
            end
            if (out_valid && !out_ready) check("stall_in_ready", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
               if (sbq.size() == 0) begin
                  check("unexpected_beat", 32'd1, 32'd0);
               end else begin
                  e = sbq.pop_front();
                  check("beat_addr", out_addr, e.addr);
                  check("beat_err", 32'(out_err), 32'(!ref_legal(e.b)));
                  if (e.b.exact) check("beat_exact", out_instr, e.b.exp_instr);
                  else if (!ref_legal(e.b)) check("beat_nop", out_instr, 32'h00000013);
                  else check("beat_fields", 32'(ref_fields_ok(e.b, out_instr)), 32'd1);
                  m_pops++;
               end
            end
            hold_vld = out_valid && !out_ready;
            hold_instr = out_instr; hold_addr = out_addr; hold_err = out_err;
            if (in_valid && in_ready) begin
               nb.fmt = fmt; nb.op = opcode; nb.rd = rd; nb.rs1 = rs1; nb.rs2 = rs2;
               nb.f3 = funct3; nb.f7 = funct7; nb.imm = imm;
               nb.exact = cur_exact; nb.exp_instr = cur_exp;
               sbq.push_back('{b: nb, addr: m_addr});
               m_addr = m_addr + 32'd4;
               if (!ref_legal(nb) && m_err < 255) m_err++;
            end
         end
      end
   end

   task automatic start_burst(input logic [31:0] base, input logic [15:0] n);
      start = 1'b1; base_addr = base; num_instr = n;
      m_addr = base & 32'hFFFFFFFC; m_err = 0; m_pops = 0;
      @(posedge clk); #2;
      start = 1'b0;
   endtask

   task automatic send(input beat_t b);
      bit got = 1'b0;
      fmt = b.fmt; opcode = b.op; rd = b.rd; rs1 = b.rs1; rs2 = b.rs2;
      funct3 = b.f3; funct7 = b.f7; imm = b.imm;
      cur_exact = b.exact; cur_exp = b.exp_instr; in_valid = 1'b1;
      for (int t = 0; t < 100 && !got; t++) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk); #2;
      end
      if (!got) check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_done(input int n);
      bit seen = 1'b0;
      in_valid = 1'b0;
      for (int t = 0; t < 300 && !seen; t++) begin
         @(negedge clk);
         seen = done;
      end
      if (!seen) begin
         check("done_timeout", 32'd0, 32'd1);
      end else begin
         check("done_err_cnt", 32'(err_cnt), 32'(m_err));
         check("done_beats", 32'(m_pops), 32'(n));
         check("done_queue_empty", 32'(sbq.size()), 32'd0);
         @(negedge clk);
         check("done_pulse_width", 32'(done), 32'd0);
         check("idle_busy", 32'(busy), 32'd0);
      end
      @(posedge clk); #2;
   endtask

   initial begin
      int c0;
      vec[0] = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFF, 32'hFFF00093);
      vec[1] = mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'h00000008, 32'h0020A423);
      vec[2] = mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFC, 32'hFE000EE3);
      vec[3] = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00000800, 32'h001000EF);
      vec[4] = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000, 32'h123452B7);
      vec[5] = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00000800, 32'h00000013);
      vec[6] = mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'h00000003, 32'h00000013);
      vec[7] = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h00000001, 32'h00000013);
      vec[8] = mk(3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'h00000000, 32'h00000013);

      rst_n = 1'b0; start = 1'b0; base_addr = 0; num_instr = 0; in_valid = 1'b0; out_ready = 1'b1;
      fmt = 0; opcode = 0; rd = 0; rs1 = 0; rs2 = 0; funct3 = 0; funct7 = 0; imm = 0;
      #3;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_instr", out_instr, 32'd0);
      check("rst_out_addr", out_addr, 32'd0);
      check("rst_out_err", 32'(out_err), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      @(posedge clk); #2; rst_n = 1'b1;
      @(posedge clk); #2;

      start_burst(32'h100, 16'd1);
      send(vec[0]);
      wait_done(1);

      start_burst(32'h100, 16'd4);
      c0 = cyc;
      for (int i = 1; i <= 4; i++) send(vec[i]);
      check("b2b_cycles", 32'(cyc - c0), 32'd4);
      wait_done(4);

      start_burst(32'h400, 16'd4);
      for (int i = 5; i <= 8; i++) send(vec[i]);
      wait_done(4);
      check("illegal_err_cnt", 32'(err_cnt), 32'd4);

      start_burst(32'h500, 16'd4);
      send(rand_beat());
      send(rand_beat());
      out_ready = 1'b0;
      fork
         send(rand_beat());
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      send(rand_beat());
      wait_done(4);

      start_burst(32'hFFFFFFFE, 16'd2);
      send(rand_beat());
      send(rand_beat());
      wait_done(2);
      check("wrap_next_addr", m_addr, 32'h00000004);

      start_burst(32'h40, 16'd0);
      @(negedge clk);
      check("n0_busy", 32'(busy), 32'd1);
      check("n0_done_early", 32'(done), 32'd0);
      @(negedge clk);
      check("n0_done", 32'(done), 32'd1);
      check("n0_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("n0_done_clear", 32'(done), 32'd0);
      check("n0_idle", 32'(busy), 32'd0);
      @(posedge clk); #2;

      start_burst(32'h200, 16'd2);
      send(rand_beat());
      start = 1'b1; base_addr = 32'h900; num_instr = 16'd7;
      send(rand_beat());
      start = 1'b0;
      wait_done(2);

      start_burst(32'h300, 16'd3);
      out_ready = 1'b0;
      send(rand_beat());
      check("pre_rst_out_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_out_instr", out_instr, 32'd0);
      check("mid_rst_out_addr", out_addr, 32'd0);
      check("mid_rst_busy", 32'(busy | done | out_err | in_ready), 32'd0);
      check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
      sbq.delete();
      @(posedge clk); #2; rst_n = 1'b1; out_ready = 1'b1;
      start_burst(32'h300, 16'd2);
      send(rand_beat());
      send(rand_beat());
      wait_done(2);

      rand_rdy = 1'b1;
      for (int k = 0; k < 8; k++) begin
         int n = $urandom_range(3, 12);
         start_burst($urandom, 16'(n));
         for (int j = 0; j < n; j++) send(rand_beat());
         wait_done(n);
      end
      rand_rdy = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
